// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC and issues one imem read at a time.
// Ports: clk, rst(n) | imem req/resp | decode stall, redirect | inst/valid/pc out
module fetch_stage #(
  parameter int          INST_LEN = 32,
  parameter int          ARCH_LEN = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_1000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ARCH_LEN-1:0] imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [INST_LEN-1:0] imem_resp_data,
  input  logic                stall_dec_in,
  input  logic                redirect_valid,
  input  logic [ARCH_LEN-1:0] redirect_pc,
  output logic [INST_LEN-1:0] inst_fetched_out,
  output logic                inst_valid_out,
  output logic [ARCH_LEN-1:0] pc_out
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [ARCH_LEN-1:0] pc_q, pc_d;
  logic                drop_q, drop_d;
  logic                skid_vld_q, skid_vld_d;
  logic [INST_LEN-1:0] skid_data_q, skid_data_d;
  logic [ARCH_LEN-1:0] skid_pc_q, skid_pc_d;
  logic                out_vld_q, out_vld_d;
  logic [INST_LEN-1:0] out_data_q, out_data_d;
  logic [ARCH_LEN-1:0] out_pc_q, out_pc_d;

  logic st_fetch, st_wait, st_hold;
  logic req_fire, slot_free, wait_busy;

  assign st_fetch = (state_q == S_FETCH);
  assign st_wait  = (state_q == S_WAIT);
  assign st_hold  = (state_q == S_HOLD);

  assign imem_req_valid = rst & st_fetch
                        & ~redirect_valid;
  assign imem_req_addr  = pc_q;
  assign req_fire  = imem_req_valid & imem_req_ready;
  assign slot_free = ~out_vld_q | ~stall_dec_in;

  // A request is still in flight and its response has not
  // shown up yet: it must be swallowed before issuing again.
  assign wait_busy = st_wait & ~imem_resp_valid;

  assign inst_fetched_out = out_data_q;
  assign inst_valid_out   = out_vld_q;
  assign pc_out           = out_pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_pc_d    = out_pc_q;
    if (redirect_valid) begin
      state_d    = wait_busy ? S_WAIT : S_FETCH;
      drop_d     = wait_busy;
      pc_d       = redirect_pc & ~ARCH_LEN'(3);
      out_vld_d  = 1'b0;
      out_data_d = NOP_INST;
      skid_vld_d = 1'b0;
    end else begin
      if (out_vld_q && !stall_dec_in) begin
        out_vld_d  = 1'b0;
        out_data_d = NOP_INST;
      end
      unique case (1'b1)
        st_fetch: begin
          if (req_fire) begin
            state_d = S_WAIT;
            pc_d    = pc_q + ARCH_LEN'(4);
          end
        end
        st_wait: begin
          if (imem_resp_valid) begin
            state_d = S_FETCH;
            drop_d  = 1'b0;
            if (!drop_q) begin
              if (slot_free) begin
                out_vld_d  = 1'b1;
                out_data_d = imem_resp_data;
                out_pc_d   = pc_q - ARCH_LEN'(4);
              end else begin
                skid_vld_d  = 1'b1;
                skid_data_d = imem_resp_data;
                skid_pc_d   = pc_q - ARCH_LEN'(4);
                state_d     = S_HOLD;
              end
            end
          end
        end
        st_hold: begin
          if (slot_free) begin
            out_vld_d  = 1'b1;
            out_data_d = skid_data_q;
            out_pc_d   = skid_pc_q;
            skid_vld_d = 1'b0;
            state_d    = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // An outstanding read survives reset in the memory; park
      // in WAIT with drop set so its late response is absorbed.
      state_q     <= wait_busy ? S_WAIT : S_FETCH;
      drop_q      <= wait_busy;
      pc_q        <= RESET_PC[ARCH_LEN-1:0];
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_pc_q   <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= NOP_INST[INST_LEN-1:0];
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      pc_q        <= pc_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_pc_q    <= out_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage.
// Memory model + request/output monitors check against queued expectations.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        stall_dec_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] inst_fetched_out;
  logic        inst_valid_out;
  logic [31:0] pc_out;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .stall_dec_in     (stall_dec_in),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .inst_fetched_out (inst_fetched_out),
    .inst_valid_out   (inst_valid_out),
    .pc_out           (pc_out)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int budget = 0;
  int lat    = 1;
  int acc_cnt = 0;

  logic [31:0] exp_req[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp_inst[$];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [31:0] memfn(logic [31:0] a);
    if (a == 32'h1000) return 32'h0050_0093;
    if (a == 32'h1004) return 32'h00A0_0113;
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic push_out(logic [31:0] p, logic [31:0] i);
    exp_pc.push_back(p);
    exp_inst.push_back(i);
  endtask

  // memory model: accepts, counts, answers after lat cycles
  initial begin
    logic        acc;
    logic        pend;
    logic [31:0] aaddr;
    logic [31:0] paddr;
    int          cnt;
    acc = 0; pend = 0; cnt = 0;
    aaddr = 0; paddr = 0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      acc = rst && imem_req_valid && imem_req_ready;
      if (acc) begin
        aaddr = imem_req_addr;
        acc_cnt++;
        budget--;
        if (exp_req.size() == 0) begin
          n_chk++;
          $display("FAIL req_unexpected: got %h want none",
                   aaddr);
        end else begin
          chk("req_addr", aaddr, exp_req.pop_front());
        end
      end
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (acc) begin
        pend  = 1;
        paddr = aaddr;
        cnt   = lat - 1;
      end
      if (pend) begin
        if (cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = memfn(paddr);
          pend = 0;
        end else begin
          cnt--;
        end
      end
      imem_req_ready = (budget > 0);
    end
  end

  // output monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) chk("req_valid_in_reset",
                    {31'd0, imem_req_valid}, 32'd0);
      if (!inst_valid_out)
        chk("nop_when_invalid", inst_fetched_out, NOP);
      if (rst && inst_valid_out && !stall_dec_in) begin
        if (exp_pc.size() == 0) begin
          n_chk++;
          $display("FAIL out_unexpected: got pc %h inst %h want none",
                   pc_out, inst_fetched_out);
        end else begin
          chk("out_pc", pc_out, exp_pc.pop_front());
          chk("out_inst", inst_fetched_out,
              exp_inst.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    budget = 0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    stall_dec_in = 1'b0;
    cyc(6);
    @(negedge clk);
    chk("rst_valid", {31'd0, inst_valid_out}, 32'd0);
    chk("rst_inst", inst_fetched_out, NOP);
    chk("rst_pc_out", pc_out, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain(string nm);
    bit done;
    done = 0;
    for (int i = 0; i < 300; i++) begin
      if (exp_req.size() == 0 && exp_pc.size() == 0) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    cyc(4);
    n_chk++;
    if (done && exp_req.size() == 0 && exp_pc.size() == 0)
      n_pass++;
    else
      $display("FAIL drain_%s: got %0d/%0d left want 0/0", nm,
               exp_req.size(), exp_pc.size());
    exp_req.delete();
    exp_pc.delete();
    exp_inst.delete();
  endtask

  task automatic wait_acc(int target);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (acc_cnt >= target) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL wait_acc: got %0d want %0d", acc_cnt,
               target);
    end
  endtask

  initial begin
    int base;
    bit seen;
    rst = 1'b0;
    stall_dec_in = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    // basic streaming
    do_reset();
    lat = 1;
    exp_req.push_back(32'h1000);
    exp_req.push_back(32'h1004);
    push_out(32'h1000, 32'h0050_0093);
    push_out(32'h1004, 32'h00A0_0113);
    budget = 2;
    drain("stream");

    // stall with skid
    do_reset();
    lat = 1;
    stall_dec_in = 1'b1;
    exp_req.push_back(32'h1000);
    exp_req.push_back(32'h1004);
    exp_req.push_back(32'h1008);
    push_out(32'h1000, 32'h0050_0093);
    push_out(32'h1004, 32'h00A0_0113);
    push_out(32'h1008, 32'h1357_8BD7);
    budget = 3;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (inst_valid_out) begin
        seen = 1;
        break;
      end
    end
    chk("stall_seen_valid", {31'd0, seen}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_valid", {31'd0, inst_valid_out}, 32'd1);
      chk("stall_pc", pc_out, 32'h1000);
      chk("stall_inst", inst_fetched_out, 32'h0050_0093);
      if (i >= 2)
        chk("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    stall_dec_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("skid_pc", pc_out, 32'h1004);
    chk("skid_valid", {31'd0, inst_valid_out}, 32'd1);
    drain("stall");

    // redirect while waiting
    do_reset();
    lat = 3;
    base = acc_cnt;
    exp_req.push_back(32'h1000);
    exp_req.push_back(32'h1004);
    exp_req.push_back(32'h2000);
    exp_req.push_back(32'h2004);
    push_out(32'h1000, 32'h0050_0093);
    push_out(32'h2000, 32'h1357_BBDF);
    push_out(32'h2004, 32'h1357_BBDB);
    budget = 4;
    wait_acc(base + 2);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h2003;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    drain("redir_wait");

    // redirect same cycle as response
    do_reset();
    lat = 1;
    base = acc_cnt;
    exp_req.push_back(32'h1000);
    exp_req.push_back(32'h2000);
    exp_req.push_back(32'h2004);
    push_out(32'h2000, 32'h1357_BBDF);
    push_out(32'h2004, 32'h1357_BBDB);
    budget = 3;
    wait_acc(base + 1);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h2000;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_resp_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("redir_resp_req_addr", imem_req_addr, 32'h2000);
    drain("redir_resp");

    // pc wrap
    do_reset();
    lat = 1;
    cyc(2);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0000_0000);
    push_out(32'hFFFF_FFFC, 32'hECA8_6423);
    push_out(32'h0000_0000, 32'h1357_9BDF);
    budget = 2;
    drain("wrap");

    // reset mid-wait with late response
    do_reset();
    lat = 4;
    base = acc_cnt;
    exp_req.push_back(32'h1000);
    budget = 1;
    wait_acc(base + 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_req.push_back(32'h1000);
    push_out(32'h1000, 32'h0050_0093);
    budget = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_no_req", {31'd0, imem_req_valid}, 32'd0);
      chk("late_valid", {31'd0, inst_valid_out}, 32'd0);
      chk("late_pc_out", pc_out, 32'd0);
    end
    drain("rst_wait");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
